// File: rtl/alu_ctrl_pipe.sv
// ALU control decoder with PIPE_STAGES elastic register stages, an illegal-instruction
// flag, flush, and a busy interlock that holds off requests while mul/div is occupied.
module alu_ctrl_pipe #(
    parameter int unsigned CTRL_W      = 4,
    parameter int unsigned PIPE_STAGES = 1,
    parameter int unsigned MULDIV_LAT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        func,
    input  logic [5:0]        opcode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              illegal,
    output logic              muldiv,
    output logic              busy
);

    localparam int unsigned LAST  = PIPE_STAGES - 1;
    localparam int unsigned CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;

    typedef enum logic [3:0] {
        C_AND  = 4'b0000,
        C_OR   = 4'b0001,
        C_ADD  = 4'b0010,
        C_XOR  = 4'b0011,
        C_SUB  = 4'b0110,
        C_SLT  = 4'b0111,
        C_SLTU = 4'b1000,
        C_SLL  = 4'b1001,
        C_SRL  = 4'b1010,
        C_SRA  = 4'b1011,
        C_NOR  = 4'b1100,
        C_LUI  = 4'b1101,
        C_MULT = 4'b1110,
        C_DIV  = 4'b1111
    } alu_code_e;

    alu_code_e              dec_code;
    logic                   dec_illegal;
    logic                   dec_muldiv;
    logic                   accept;
    logic                   stage_full;
    logic [PIPE_STAGES-1:0] valid;
    logic [PIPE_STAGES-1:0] load;
    logic [PIPE_STAGES-1:0] ill_q;
    logic [PIPE_STAGES-1:0] md_q;
    logic [3:0]             code_q [PIPE_STAGES];
    logic [CNT_W-1:0]       busy_cnt;

    always_comb begin
        dec_code    = C_ADD;
        dec_illegal = 1'b0;
        case (alu_op)
            2'b00: dec_code = C_ADD;
            2'b01: dec_code = C_SUB;
            2'b10: begin
                case (func)
                    6'b100000: dec_code = C_ADD;
                    6'b100010: dec_code = C_SUB;
                    6'b100100: dec_code = C_AND;
                    6'b100101: dec_code = C_OR;
                    6'b100110: dec_code = C_XOR;
                    6'b100111: dec_code = C_NOR;
                    6'b101010: dec_code = C_SLT;
                    6'b101011: dec_code = C_SLTU;
                    6'b000000: dec_code = C_SLL;
                    6'b000010: dec_code = C_SRL;
                    6'b000011: dec_code = C_SRA;
                    6'b011000: dec_code = C_MULT;
                    6'b011010: dec_code = C_DIV;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            default: begin
                case (opcode)
                    6'b001000: dec_code = C_ADD;
                    6'b001100: dec_code = C_AND;
                    6'b001101: dec_code = C_OR;
                    6'b001110: dec_code = C_XOR;
                    6'b001010: dec_code = C_SLT;
                    6'b001011: dec_code = C_SLTU;
                    6'b001111: dec_code = C_LUI;
                    default:   dec_illegal = 1'b1;
                endcase
            end
        endcase
        dec_muldiv = (dec_code == C_MULT) || (dec_code == C_DIV);
    end

    // Stage i can load unless it and every stage after it are full and the output is stalled;
    // written in closed form rather than as a back-to-front ripple.
    always_comb begin
        load       = '0;
        stage_full = 1'b1;
        for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
            stage_full = 1'b1;
            for (int unsigned k = i; k < PIPE_STAGES; k++) begin
                stage_full = stage_full & valid[k];
            end
            load[i] = !stage_full || out_ready;
        end
    end

    assign in_ready = load[0] && (busy_cnt == '0) && !rst && !flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= '0;
            ill_q    <= '0;
            md_q     <= '0;
            busy_cnt <= '0;
            for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
                code_q[i] <= '0;
            end
        end else if (flush) begin
            valid    <= '0;
            busy_cnt <= '0;
        end else begin
            if (load[0]) begin
                valid[0] <= accept;
                if (accept) begin
                    code_q[0] <= dec_code;
                    ill_q[0]  <= dec_illegal;
                    md_q[0]   <= dec_muldiv;
                end
            end
            for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
                if (load[i]) begin
                    valid[i] <= valid[i-1];
                    if (valid[i-1]) begin
                        code_q[i] <= code_q[i-1];
                        ill_q[i]  <= ill_q[i-1];
                        md_q[i]   <= md_q[i-1];
                    end
                end
            end
            if (accept && dec_muldiv) begin
                busy_cnt <= CNT_W'(MULDIV_LAT - 1);
            end else if (busy_cnt != '0) begin
                busy_cnt <= busy_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        alu_ctrl      = '0;
        alu_ctrl[3:0] = code_q[LAST];
    end

    assign out_valid = valid[LAST];
    assign illegal   = ill_q[LAST];
    assign muldiv    = md_q[LAST];
    assign busy      = (busy_cnt != '0);

endmodule

// File: doc/alu_ctrl_pipe.md
Name: alu_ctrl_pipe

Overview:
Parametrised, pipelined successor to the single-cycle ALU control decoder. Decodes ALUOp plus funct (R-type) or opcode (I-type) into an ALU control code, and passes it through PIPE_STAGES elastic register stages with a valid/ready handshake. Adds an illegal-instruction flag, a flush, and a busy interlock for multi-cycle MULT/DIV operations. Sits between the main control unit and the execute stage.

Parameters:
CTRL_W  4  width of alu_ctrl output; must be >=4; bits above [3] are driven 0
PIPE_STAGES  1  number of register stages, legal range 1..3; sets latency
MULDIV_LAT  4  cycles the mul/div unit is occupied per MULT/DIV op; legal range >=1

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous; drops all in-flight tokens and clears busy
in_valid  in  1  upstream has a decode request
in_ready  out  1  block accepts a request this cycle
alu_op  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type
func  in  6  instruction[5:0]
opcode  in  6  instruction[31:26]; used only when alu_op=11
out_valid  out  1  alu_ctrl/illegal/muldiv valid
out_ready  in  1  downstream accepts
alu_ctrl  out  CTRL_W  decoded ALU control code
illegal  out  1  request did not decode; alu_ctrl forced to ADD
muldiv  out  1  token is MULT or DIV
busy  out  1  mul/div occupancy counter non-zero

Behaviour:
- Codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, SLTU 1000, SLL 1001, SRL 1010, SRA 1011, NOR 1100, LUI 1101, MULT 1110, DIV 1111.
- alu_op=00 -> ADD. alu_op=01 -> SUB. func/opcode ignored; never illegal.
- alu_op=10 funct map: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 101011 SLTU, 000000 SLL, 000010 SRL, 000011 SRA, 011000 MULT, 011010 DIV. Any other funct -> ADD with illegal=1.
- alu_op=11 opcode map: 001000 ADD, 001100 AND, 001101 OR, 001110 XOR, 001010 SLT, 001011 SLTU, 001111 LUI. Any other opcode -> ADD with illegal=1.
- muldiv=1 iff the code is MULT or DIV.
- Decode is combinational into stage 0. Each stage i holds valid_i plus its payload. Stage i loads when !valid_i or stage i+1 (or the output for the last stage) accepts this cycle. Full throughput: one token per cycle when out_ready=1.
- Latency: accepted at edge N -> out_valid at edge N+PIPE_STAGES-1 output window, i.e. visible PIPE_STAGES cycles after the accepting edge, with no stall.
- Stall: out_ready=0 with out_valid=1 holds all outputs stable. Bubbles compress, so upstream stages still fill.
- in_ready = (!valid_0 || stage 0 advances) && (busy_cnt==0) && !rst && !flush.
- Busy interlock: accepting a muldiv token loads busy_cnt=MULDIV_LAT-1. busy_cnt decrements each cycle to 0. busy = (busy_cnt!=0). With MULDIV_LAT=1, no stall occurs. The muldiv token itself flows normally.
- flush: next edge clears all valid_i and busy_cnt; the request presented in the flush cycle is not accepted. Payload registers may keep stale values.
- Simultaneous flush and out_ready: the output token is considered consumed.
- Reset (and reset mid-operation): all valid_i=0, out_valid=0, alu_ctrl=0, illegal=0, muldiv=0, busy_cnt=0, busy=0. in_ready=0 while rst high. First acceptance is possible in the cycle after rst falls.
- Payload registers load only on stage load, so there is no X-propagation into outputs after reset.

Test Plan:
- PIPE_STAGES=1, out_ready=1: stream alu_op=10 with funct 100000,100010,100100,100101,101010 on consecutive cycles -> alu_ctrl 0010,0110,0000,0001,0111 one cycle later each, out_valid continuously 1, illegal=0.
- alu_op=10 funct 111111, then alu_op=11 opcode 000001 -> alu_ctrl=0010, illegal=1 for both. alu_op=00 and 01 with arbitrary func -> 0010 and 0110, illegal=0.
- PIPE_STAGES=3: hold out_ready=0 for 5 cycles while feeding 4 tokens -> exactly 3 accepted, then in_ready=0. Release -> tokens emerge in order with no loss or duplication.
- MULDIV_LAT=4: accept funct 011000 -> muldiv=1 on output, busy=1 and in_ready=0 for 3 cycles, then in_ready=1. A back-to-back ADD request is accepted on the 4th cycle after the MULT.
- With 2 tokens in flight and busy=1, pulse flush -> next cycle out_valid=0, busy=0, in_ready=1. The request offered during flush never appears at the output.
- Assert rst mid-stream with out_valid=1 -> next edge all outputs 0, in_ready=0 during rst. After release, a fresh ADD decodes normally with latency PIPE_STAGES.
